// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: op codes, flags, and the entry record.
package alu_reservation_station_pkg;

    localparam int GPR_SIZE     = 32;
    localparam int ROB_IDX_SIZE = 5;

    typedef enum logic [3:0] {
        ALU_PLUS  = 4'd0,
        ALU_MINUS = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_LSL   = 4'd5,
        ALU_LSR   = 4'd6,
        ALU_CSEL  = 4'd7,
        ALU_MOV   = 4'd8
    } alu_op_t;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic                    valid;
        alu_op_t                 op;
        logic                    a_ready;
        logic [ROB_IDX_SIZE-1:0] a_rob_index;
        logic [GPR_SIZE-1:0]     a_value;
        logic                    b_ready;
        logic [ROB_IDX_SIZE-1:0] b_rob_index;
        logic [GPR_SIZE-1:0]     b_value;
        logic                    nzcv_ready;
        logic [ROB_IDX_SIZE-1:0] nzcv_rob_index;
        nzcv_t                   nzcv;
        logic                    set_nzcv;
        logic [ROB_IDX_SIZE-1:0] dst_rob_index;
    } rs_entry_t;

    // A waiting operand is satisfied by a broadcast carrying its producer tag.
    function automatic logic tag_hit(
        input logic                    ready,
        input logic [ROB_IDX_SIZE-1:0] tag,
        input logic                    bus_valid,
        input logic [ROB_IDX_SIZE-1:0] bus_tag
    );
        return ~ready & bus_valid & (tag == bus_tag);
    endfunction

endpackage

// File: rtl/alu_reservation_station_age_select.sv
// Oldest-first picker: grants the eligible entry that is older than every other eligible entry.
module rs_age_select
    import alu_reservation_station_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0][N-1:0] i_age,
    input  logic [N-1:0]        i_eligible,
    output logic [N-1:0]        o_grant,
    output logic                o_any_eligible
);

    // Row i of the age matrix has bit j set when entry i is older than entry j.
    always_comb begin : p_grant
        logic w_older;
        for (int i = 0; i < N; i++) begin
            w_older = 1'b1;
            for (int j = 0; j < N; j++) begin
                w_older = w_older & ((i == j) | ~i_eligible[j] | i_age[i][j]);
            end
            o_grant[i] = i_eligible[i] & w_older;
        end
    end

    assign o_any_eligible = |i_eligible;

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched micro-ops until operands arrive on the
// result bus, then issues the oldest ready one to the ALU.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE = 8
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic                    in_flush,
    input  logic                    in_dispatch_valid,
    input  alu_op_t                 in_dispatch_op,
    input  logic [GPR_SIZE-1:0]     in_dispatch_val_a,
    input  logic [GPR_SIZE-1:0]     in_dispatch_val_b,
    input  logic                    in_dispatch_a_ready,
    input  logic                    in_dispatch_b_ready,
    input  logic                    in_dispatch_nzcv_ready,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_a_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_b_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_nzcv_rob_index,
    input  nzcv_t                   in_dispatch_nzcv,
    input  logic                    in_dispatch_set_nzcv,
    input  logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index,
    output logic                    out_dispatch_ready,
    input  logic                    in_fu_done,
    input  logic [ROB_IDX_SIZE-1:0] in_fu_dst_rob_index,
    input  logic [GPR_SIZE-1:0]     in_fu_value,
    input  logic                    in_fu_set_nzcv,
    input  nzcv_t                   in_fu_nzcv,
    input  logic                    in_alu_ready,
    output logic                    out_alu_start,
    output alu_op_t                 out_alu_op,
    output logic [GPR_SIZE-1:0]     out_alu_val_a,
    output logic [GPR_SIZE-1:0]     out_alu_val_b,
    output logic [ROB_IDX_SIZE-1:0] out_alu_dst_rob_index,
    output logic                    out_alu_set_nzcv,
    output nzcv_t                   out_alu_nzcv
);

    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t                       r_entry [RS_SIZE];
    logic [RS_SIZE-1:0][RS_SIZE-1:0] r_age;

    rs_entry_t                       w_kept [RS_SIZE];
    rs_entry_t                       w_new;
    logic [RS_SIZE-1:0]              w_valid;
    logic [RS_SIZE-1:0]              w_eligible;
    logic [RS_SIZE-1:0]              w_grant;
    logic [RS_SIZE-1:0]              w_wake_a;
    logic [RS_SIZE-1:0]              w_wake_b;
    logic [RS_SIZE-1:0]              w_wake_n;
    logic                            w_any_eligible;
    logic                            w_issue;
    logic                            w_alloc;
    logic                            w_byp_a;
    logic                            w_byp_b;
    logic                            w_byp_n;
    logic [IDX_W-1:0]                w_free_idx;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] w_age_nxt;
    logic [$bits(alu_op_t)-1:0]      w_sel_op;
    logic [GPR_SIZE-1:0]             w_sel_a;
    logic [GPR_SIZE-1:0]             w_sel_b;
    logic [ROB_IDX_SIZE-1:0]         w_sel_dst;
    logic                            w_sel_setn;
    nzcv_t                           w_sel_nzcv;

    // Per-entry status: occupancy, issue eligibility and broadcast wakeup hits.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_valid[i]    = r_entry[i].valid;
            w_eligible[i] = r_entry[i].valid & r_entry[i].a_ready
                          & r_entry[i].b_ready & r_entry[i].nzcv_ready;
            w_wake_a[i]   = r_entry[i].valid & tag_hit(r_entry[i].a_ready, r_entry[i].a_rob_index,
                                                       in_fu_done, in_fu_dst_rob_index);
            w_wake_b[i]   = r_entry[i].valid & tag_hit(r_entry[i].b_ready, r_entry[i].b_rob_index,
                                                       in_fu_done, in_fu_dst_rob_index);
            w_wake_n[i]   = r_entry[i].valid & tag_hit(r_entry[i].nzcv_ready, r_entry[i].nzcv_rob_index,
                                                       in_fu_done & in_fu_set_nzcv, in_fu_dst_rob_index);
        end
    end

    // Lowest-index free slot; only meaningful while the station is not full.
    always_comb begin
        w_free_idx = {IDX_W{1'b0}};
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            w_free_idx = w_valid[i] ? w_free_idx : IDX_W'(i);
        end
    end

    assign out_dispatch_ready = ~(&w_valid);
    assign w_alloc            = in_dispatch_valid & out_dispatch_ready & ~in_flush;
    assign w_issue            = w_any_eligible & in_alu_ready & ~in_flush;
    assign out_alu_start      = w_issue;

    assign w_byp_a = tag_hit(in_dispatch_a_ready, in_dispatch_a_rob_index, in_fu_done, in_fu_dst_rob_index);
    assign w_byp_b = tag_hit(in_dispatch_b_ready, in_dispatch_b_rob_index, in_fu_done, in_fu_dst_rob_index);
    assign w_byp_n = tag_hit(in_dispatch_nzcv_ready, in_dispatch_nzcv_rob_index,
                             in_fu_done & in_fu_set_nzcv, in_fu_dst_rob_index);

    // New entry, picking up a result broadcast in the same cycle as dispatch.
    always_comb begin
        w_new.valid          = 1'b1;
        w_new.op             = in_dispatch_op;
        w_new.a_ready        = in_dispatch_a_ready | w_byp_a;
        w_new.a_rob_index    = in_dispatch_a_rob_index;
        w_new.a_value        = w_byp_a ? in_fu_value : in_dispatch_val_a;
        w_new.b_ready        = in_dispatch_b_ready | w_byp_b;
        w_new.b_rob_index    = in_dispatch_b_rob_index;
        w_new.b_value        = w_byp_b ? in_fu_value : in_dispatch_val_b;
        w_new.nzcv_ready     = in_dispatch_nzcv_ready | w_byp_n;
        w_new.nzcv_rob_index = in_dispatch_nzcv_rob_index;
        w_new.nzcv           = w_byp_n ? in_fu_nzcv : in_dispatch_nzcv;
        w_new.set_nzcv       = in_dispatch_set_nzcv;
        w_new.dst_rob_index  = in_dispatch_dst_rob_index;
    end

    // Resident entries: capture wakeups, drop the issued entry, clear all on flush.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_kept[i]            = r_entry[i];
            w_kept[i].a_ready    = r_entry[i].a_ready | w_wake_a[i];
            w_kept[i].a_value    = w_wake_a[i] ? in_fu_value : r_entry[i].a_value;
            w_kept[i].b_ready    = r_entry[i].b_ready | w_wake_b[i];
            w_kept[i].b_value    = w_wake_b[i] ? in_fu_value : r_entry[i].b_value;
            w_kept[i].nzcv_ready = r_entry[i].nzcv_ready | w_wake_n[i];
            w_kept[i].nzcv       = w_wake_n[i] ? in_fu_nzcv : r_entry[i].nzcv;
            w_kept[i].valid      = r_entry[i].valid & ~(w_issue & w_grant[i]) & ~in_flush;
        end
    end

    // A newly allocated entry is younger than everything currently valid.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                w_age_nxt[i][j] = (w_alloc && (w_free_idx == IDX_W'(i))) ? 1'b0 :
                                  (w_alloc && (w_free_idx == IDX_W'(j))) ? w_valid[i] :
                                  r_age[i][j];
            end
        end
    end

    rs_age_select #(
        .N (RS_SIZE)
    ) u_age_select (
        .i_age          (r_age),
        .i_eligible     (w_eligible),
        .o_grant        (w_grant),
        .o_any_eligible (w_any_eligible)
    );

    // One-hot mux of the granted entry onto the issue fields.
    always_comb begin
        w_sel_op   = {$bits(alu_op_t){1'b0}};
        w_sel_a    = {GPR_SIZE{1'b0}};
        w_sel_b    = {GPR_SIZE{1'b0}};
        w_sel_dst  = {ROB_IDX_SIZE{1'b0}};
        w_sel_setn = 1'b0;
        w_sel_nzcv = 4'b0000;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_sel_op   = w_sel_op   | ({$bits(alu_op_t){w_grant[i]}} & r_entry[i].op);
            w_sel_a    = w_sel_a    | ({GPR_SIZE{w_grant[i]}} & r_entry[i].a_value);
            w_sel_b    = w_sel_b    | ({GPR_SIZE{w_grant[i]}} & r_entry[i].b_value);
            w_sel_dst  = w_sel_dst  | ({ROB_IDX_SIZE{w_grant[i]}} & r_entry[i].dst_rob_index);
            w_sel_setn = w_sel_setn | (w_grant[i] & r_entry[i].set_nzcv);
            w_sel_nzcv = w_sel_nzcv | ({4{w_grant[i]}} & r_entry[i].nzcv);
        end
    end

    assign out_alu_op            = w_issue ? alu_op_t'(w_sel_op) : ALU_PLUS;
    assign out_alu_val_a         = w_issue ? w_sel_a : {GPR_SIZE{1'b0}};
    assign out_alu_val_b         = w_issue ? w_sel_b : {GPR_SIZE{1'b0}};
    assign out_alu_dst_rob_index = w_issue ? w_sel_dst : {ROB_IDX_SIZE{1'b0}};
    assign out_alu_set_nzcv      = w_issue & w_sel_setn;
    assign out_alu_nzcv          = w_issue ? w_sel_nzcv : 4'b0000;

    // Entry and age state registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_entry[i] <= {$bits(rs_entry_t){1'b0}};
            end
            r_age <= {(RS_SIZE * RS_SIZE){1'b0}};
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                r_entry[i] <= (w_alloc && (w_free_idx == IDX_W'(i))) ? w_new : w_kept[i];
            end
            r_age <= w_age_nxt;
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with a queue-based issue scoreboard.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic                    in_clk;
    logic                    in_rst_n;
    logic                    in_flush;
    logic                    in_dispatch_valid;
    alu_op_t                 in_dispatch_op;
    logic [GPR_SIZE-1:0]     in_dispatch_val_a;
    logic [GPR_SIZE-1:0]     in_dispatch_val_b;
    logic                    in_dispatch_a_ready;
    logic                    in_dispatch_b_ready;
    logic                    in_dispatch_nzcv_ready;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_a_rob_index;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_b_rob_index;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_nzcv_rob_index;
    nzcv_t                   in_dispatch_nzcv;
    logic                    in_dispatch_set_nzcv;
    logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index;
    logic                    out_dispatch_ready;
    logic                    in_fu_done;
    logic [ROB_IDX_SIZE-1:0] in_fu_dst_rob_index;
    logic [GPR_SIZE-1:0]     in_fu_value;
    logic                    in_fu_set_nzcv;
    nzcv_t                   in_fu_nzcv;
    logic                    in_alu_ready;
    logic                    out_alu_start;
    alu_op_t                 out_alu_op;
    logic [GPR_SIZE-1:0]     out_alu_val_a;
    logic [GPR_SIZE-1:0]     out_alu_val_b;
    logic [ROB_IDX_SIZE-1:0] out_alu_dst_rob_index;
    logic                    out_alu_set_nzcv;
    nzcv_t                   out_alu_nzcv;

    typedef struct packed {
        alu_op_t                 op;
        logic [GPR_SIZE-1:0]     a;
        logic [GPR_SIZE-1:0]     b;
        logic [ROB_IDX_SIZE-1:0] dst;
        logic                    setn;
        nzcv_t                   nzcv;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    alu_reservation_station #(.RS_SIZE(8)) dut (
        .in_clk                     (in_clk),
        .in_rst_n                   (in_rst_n),
        .in_flush                   (in_flush),
        .in_dispatch_valid          (in_dispatch_valid),
        .in_dispatch_op             (in_dispatch_op),
        .in_dispatch_val_a          (in_dispatch_val_a),
        .in_dispatch_val_b          (in_dispatch_val_b),
        .in_dispatch_a_ready        (in_dispatch_a_ready),
        .in_dispatch_b_ready        (in_dispatch_b_ready),
        .in_dispatch_nzcv_ready     (in_dispatch_nzcv_ready),
        .in_dispatch_a_rob_index    (in_dispatch_a_rob_index),
        .in_dispatch_b_rob_index    (in_dispatch_b_rob_index),
        .in_dispatch_nzcv_rob_index (in_dispatch_nzcv_rob_index),
        .in_dispatch_nzcv           (in_dispatch_nzcv),
        .in_dispatch_set_nzcv       (in_dispatch_set_nzcv),
        .in_dispatch_dst_rob_index  (in_dispatch_dst_rob_index),
        .out_dispatch_ready         (out_dispatch_ready),
        .in_fu_done                 (in_fu_done),
        .in_fu_dst_rob_index        (in_fu_dst_rob_index),
        .in_fu_value                (in_fu_value),
        .in_fu_set_nzcv             (in_fu_set_nzcv),
        .in_fu_nzcv                 (in_fu_nzcv),
        .in_alu_ready               (in_alu_ready),
        .out_alu_start              (out_alu_start),
        .out_alu_op                 (out_alu_op),
        .out_alu_val_a              (out_alu_val_a),
        .out_alu_val_b              (out_alu_val_b),
        .out_alu_dst_rob_index      (out_alu_dst_rob_index),
        .out_alu_set_nzcv           (out_alu_set_nzcv),
        .out_alu_nzcv               (out_alu_nzcv)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic drive(input alu_op_t op, input logic [GPR_SIZE-1:0] a, input logic [GPR_SIZE-1:0] b,
                         input logic ar, input logic br, input logic nr,
                         input logic [ROB_IDX_SIZE-1:0] arob, input logic [ROB_IDX_SIZE-1:0] brob,
                         input logic [ROB_IDX_SIZE-1:0] nrob, input nzcv_t nz, input logic setn,
                         input logic [ROB_IDX_SIZE-1:0] dst);
        in_dispatch_valid          = 1'b1;
        in_dispatch_op             = op;
        in_dispatch_val_a          = a;
        in_dispatch_val_b          = b;
        in_dispatch_a_ready        = ar;
        in_dispatch_b_ready        = br;
        in_dispatch_nzcv_ready     = nr;
        in_dispatch_a_rob_index    = arob;
        in_dispatch_b_rob_index    = brob;
        in_dispatch_nzcv_rob_index = nrob;
        in_dispatch_nzcv           = nz;
        in_dispatch_set_nzcv       = setn;
        in_dispatch_dst_rob_index  = dst;
    endtask

    task automatic broadcast(input logic [ROB_IDX_SIZE-1:0] tag, input logic [GPR_SIZE-1:0] val,
                             input logic setn, input nzcv_t nz);
        in_fu_done          = 1'b1;
        in_fu_dst_rob_index = tag;
        in_fu_value         = val;
        in_fu_set_nzcv      = setn;
        in_fu_nzcv          = nz;
    endtask

    task automatic quiet_fu();
        in_fu_done     = 1'b0;
        in_fu_set_nzcv = 1'b0;
    endtask

    task automatic push(input alu_op_t op, input logic [GPR_SIZE-1:0] a, input logic [GPR_SIZE-1:0] b,
                        input logic [ROB_IDX_SIZE-1:0] dst, input logic setn, input nzcv_t nz);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.dst = dst; e.setn = setn; e.nzcv = nz;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && sb_q.size() != 0; c++) begin
            tick();
        end
        check("scoreboard_drained", 128'(sb_q.size()), 128'(1'b0));
    endtask

    // Monitor: every issue is matched against the oldest outstanding expectation.
    always @(negedge in_clk) begin
        exp_t e;
        exp_t g;
        if (out_alu_start) begin
            g.op = out_alu_op; g.a = out_alu_val_a; g.b = out_alu_val_b;
            g.dst = out_alu_dst_rob_index; g.setn = out_alu_set_nzcv; g.nzcv = out_alu_nzcv;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got %0h expected no issue", g);
            end else begin
                e = sb_q.pop_front();
                check("issue_fields", 128'(g), 128'(e));
            end
        end else begin
            check("idle_outputs_zero",
                  128'({out_alu_op, out_alu_val_a, out_alu_val_b, out_alu_dst_rob_index,
                        out_alu_set_nzcv, out_alu_nzcv}), 128'(1'b0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        in_rst_n = 1'b0;
        in_flush = 1'b0;
        in_dispatch_valid = 1'b0;
        drive(ALU_PLUS, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0, 5'd0);
        in_dispatch_valid = 1'b0;
        broadcast(5'd0, 32'd0, 1'b0, 4'b0000);
        quiet_fu();
        in_alu_ready = 1'b0;

        tick();
        check("reset_start", 128'(out_alu_start), 128'(1'b0));
        check("reset_dispatch_ready", 128'(out_dispatch_ready), 128'(1'b1));
        check("reset_val_a", 128'(out_alu_val_a), 128'(1'b0));
        tick();
        in_rst_n = 1'b1;
        tick();

        // Ready dispatch issues one cycle later, then goes idle.
        in_alu_ready = 1'b1;
        drive(ALU_PLUS, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0, 5'd3);
        push(ALU_PLUS, 32'd5, 32'd7, 5'd3, 1'b0, 4'b0000);
        check("t1_no_same_cycle_issue", 128'(out_alu_start), 128'(1'b0));
        tick();
        in_dispatch_valid = 1'b0;
        check("t1_issue_n1", 128'(out_alu_start), 128'(1'b1));
        tick();
        check("t1_idle_n2", 128'(out_alu_start), 128'(1'b0));

        // Wakeup of operand A on ROB 2; tag 4 must not wake it.
        drive(ALU_MINUS, 32'd0, 32'd9, 1'b0, 1'b1, 1'b1, 5'd2, 5'd0, 5'd0, 4'b0000, 1'b0, 5'd5);
        tick();
        in_dispatch_valid = 1'b0;
        check("t2_waiting", 128'(out_alu_start), 128'(1'b0));
        broadcast(5'd4, 32'd99, 1'b0, 4'b0000);
        tick();
        quiet_fu();
        check("t2_wrong_tag", 128'(out_alu_start), 128'(1'b0));
        broadcast(5'd2, 32'd40, 1'b0, 4'b0000);
        push(ALU_MINUS, 32'd40, 32'd9, 5'd5, 1'b0, 4'b0000);
        check("t2_no_same_cycle_wakeup", 128'(out_alu_start), 128'(1'b0));
        tick();
        quiet_fu();
        check("t2_issue", 128'(out_alu_start), 128'(1'b1));
        tick();

        // Same-cycle NZCV bypass, then a flag-less broadcast that must not wake.
        drive(ALU_CSEL, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd1, 4'b0000, 1'b0, 5'd6);
        broadcast(5'd1, 32'd77, 1'b1, 4'b0100);
        push(ALU_CSEL, 32'd1, 32'd2, 5'd6, 1'b0, 4'b0100);
        tick();
        in_dispatch_valid = 1'b0;
        quiet_fu();
        check("t3_bypass_issue", 128'(out_alu_start), 128'(1'b1));
        tick();
        drive(ALU_CSEL, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd1, 4'b0000, 1'b0, 5'd7);
        broadcast(5'd1, 32'd77, 1'b0, 4'b0100);
        tick();
        in_dispatch_valid = 1'b0;
        quiet_fu();
        check("t3_no_flag_wake", 128'(out_alu_start), 128'(1'b0));
        tick();
        check("t3_still_waiting", 128'(out_alu_start), 128'(1'b0));
        broadcast(5'd1, 32'd55, 1'b1, 4'b1000);
        push(ALU_CSEL, 32'd3, 32'd4, 5'd7, 1'b0, 4'b1000);
        tick();
        quiet_fu();
        check("t3_late_flag_wake", 128'(out_alu_start), 128'(1'b1));
        tick();

        // Fill under backpressure, drop the 9th, then drain oldest-first.
        in_alu_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive((i % 2 == 1) ? ALU_AND : ALU_PLUS, 32'(100 + i), 32'(i), 1'b1, 1'b1, 1'b1,
                  5'd0, 5'd0, 5'd0, 4'(i), 1'b1, 5'(8 + i));
            push((i % 2 == 1) ? ALU_AND : ALU_PLUS, 32'(100 + i), 32'(i), 5'(8 + i), 1'b1, 4'(i));
            tick();
        end
        in_dispatch_valid = 1'b0;
        check("t4_full_not_ready", 128'(out_dispatch_ready), 128'(1'b0));
        check("t4_held", 128'(out_alu_start), 128'(1'b0));
        drive(ALU_XOR, 32'd999, 32'd999, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0, 5'd31);
        tick();
        in_dispatch_valid = 1'b0;
        check("t4_still_full", 128'(out_dispatch_ready), 128'(1'b0));
        in_alu_ready = 1'b1;
        #1;
        check("t4_ready_from_regs", 128'(out_dispatch_ready), 128'(1'b0));
        tick();
        check("t4_slot_freed", 128'(out_dispatch_ready), 128'(1'b1));
        drive(ALU_OR, 32'd500, 32'd501, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0, 5'd20);
        push(ALU_OR, 32'd500, 32'd501, 5'd20, 1'b0, 4'b0000);
        tick();
        in_dispatch_valid = 1'b0;
        wait_drain(40);

        // Flush with three resident entries and a same-cycle dispatch.
        in_alu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(ALU_PLUS, 32'(i), 32'(i), 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0, 5'(10 + i));
            tick();
        end
        drive(ALU_MINUS, 32'd7, 32'd7, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0, 5'd13);
        in_flush     = 1'b1;
        in_alu_ready = 1'b1;
        #1;
        check("t5_flush_suppress", 128'(out_alu_start), 128'(1'b0));
        tick();
        in_flush = 1'b0;
        in_dispatch_valid = 1'b0;
        check("t5_empty_ready", 128'(out_dispatch_ready), 128'(1'b1));
        check("t5_no_issue", 128'(out_alu_start), 128'(1'b0));
        tick();
        check("t5_no_issue_later", 128'(out_alu_start), 128'(1'b0));

        // Asynchronous reset while an issue is being presented.
        in_alu_ready = 1'b0;
        drive(ALU_PLUS, 32'd11, 32'd12, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0, 5'd1);
        tick();
        drive(ALU_PLUS, 32'd13, 32'd14, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0, 5'd2);
        tick();
        in_dispatch_valid = 1'b0;
        in_alu_ready = 1'b1;
        #1;
        check("t6_issuing", 128'(out_alu_start), 128'(1'b1));
        check("t6_oldest_val_a", 128'(out_alu_val_a), 128'(32'd11));
        #1;
        in_rst_n = 1'b0;
        #1;
        check("t6_reset_start", 128'(out_alu_start), 128'(1'b0));
        check("t6_reset_val_a", 128'(out_alu_val_a), 128'(1'b0));
        check("t6_reset_dispatch_ready", 128'(out_dispatch_ready), 128'(1'b1));
        tick();
        tick();
        in_rst_n = 1'b1;
        tick();
        check("t6_empty_after_reset", 128'(out_alu_start), 128'(1'b0));
        tick();
        check("t6_still_empty", 128'(out_alu_start), 128'(1'b0));
        drive(ALU_PLUS, 32'd21, 32'd22, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 4'b0000, 1'b0, 5'd9);
        push(ALU_PLUS, 32'd21, 32'd22, 5'd9, 1'b0, 4'b0000);
        tick();
        in_dispatch_valid = 1'b0;
        check("t6_issue_after_reset", 128'(out_alu_start), 128'(1'b1));
        tick();
        wait_drain(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Holds dispatched ALU micro-ops until their operands (A, B, NZCV) are available, captures results broadcast by the functional units, and issues the oldest ready entry to the ALU. It sits directly upstream of `func_units`: dispatch/rename writes into it, and its issue port drives the `in_rs_alu_*` inputs of `func_units`. It snoops the `func_units` result bus (`out_rob_*`) for operand wakeup.

## Interface
- `RS_SIZE`, 8: number of entries (≥2, power of two).
- `in_clk` in 1: clock.
- `in_rst_n` in 1: reset, asynchronous, active-low.
- `in_flush` in 1: mispredict flush; empties the station.
- `in_dispatch_valid` in 1: dispatch request.
- `in_dispatch_op` in `alu_op_t`: operation.
- `in_dispatch_val_a`, `in_dispatch_val_b` in `GPR_SIZE`: operand value, valid if the matching `_ready` bit is set.
- `in_dispatch_a_ready`, `in_dispatch_b_ready`, `in_dispatch_nzcv_ready` in 1: operand already available.
- `in_dispatch_a_rob_index`, `in_dispatch_b_rob_index`, `in_dispatch_nzcv_rob_index` in `ROB_IDX_SIZE`: producer tag, used when not ready.
- `in_dispatch_nzcv` in `nzcv_t`: flags value, valid if ready.
- `in_dispatch_set_nzcv` in 1: the op writes flags.
- `in_dispatch_dst_rob_index` in `ROB_IDX_SIZE`: destination tag.
- `out_dispatch_ready` out 1: at least one free entry.
- `in_fu_done` in 1: result broadcast valid.
- `in_fu_dst_rob_index` in `ROB_IDX_SIZE`: broadcast tag.
- `in_fu_value` in `GPR_SIZE`: broadcast value.
- `in_fu_set_nzcv` in 1: broadcast carries flags.
- `in_fu_nzcv` in `nzcv_t`: broadcast flags.
- `in_alu_ready` in 1: ALU accepts an issue this cycle.
- `out_alu_start` out 1: issue valid.
- `out_alu_op` out `alu_op_t`, `out_alu_val_a`/`out_alu_val_b` out `GPR_SIZE`, `out_alu_dst_rob_index` out `ROB_IDX_SIZE`, `out_alu_set_nzcv` out 1, `out_alu_nzcv` out `nzcv_t`: issued entry fields.

## Operation
- Each entry holds: valid, op, per-operand {ready, rob_index, value} for A, B and NZCV, set_nzcv, and dst_rob_index.
- **Dispatch:** when `in_dispatch_valid & out_dispatch_ready & ~in_flush`, write the lowest-index free entry. Otherwise the request is dropped silently.
- **Dispatch bypass:** if a not-ready source tag equals `in_fu_dst_rob_index` while `in_fu_done` is high in the same cycle, store it as ready with `in_fu_value`. NZCV bypasses only if `in_fu_set_nzcv` is also high.
- **Wakeup:** for every valid entry, a not-ready A/B with a matching tag on `in_fu_done` captures `in_fu_value`. A not-ready NZCV requires `in_fu_done & in_fu_set_nzcv` and a matching tag, and captures `in_fu_nzcv`.
- **Age:** an RS_SIZE×RS_SIZE age matrix. On allocation, the new entry is younger than all valid entries.
- **Select:** an entry is eligible when valid and A, B and NZCV are all ready. Pick the oldest eligible entry.
- **Issue:** `out_alu_start = any_eligible & in_alu_ready`. Data outputs show the selected entry and are 0 when `out_alu_start` is 0. The issued entry is freed at the clock edge.
- **Flush:** all valid bits clear at the edge. Same-cycle dispatch and issue are suppressed (`out_alu_start` = 0 while `in_flush`=1).
- **Reset:** all entries invalid, age matrix cleared. `out_dispatch_ready`=1, `out_alu_start`=0, all data outputs 0.

## Timing
- Dispatch at edge N → issuable in cycle N+1 at the earliest. Minimum RS residency is 1 cycle.
- Wakeup at edge N → issuable in cycle N+1. There is no same-cycle broadcast-to-issue path.
- Issue outputs are combinational from registered entry state. `func_units` registers them at the next edge.
- `out_dispatch_ready` comes from registered valid bits only. A slot freed by an issue this cycle is not counted until the next cycle.
- Full (all RS_SIZE valid) → `out_dispatch_ready`=0. Simultaneous issue and dispatch while not full are both performed.
- `in_alu_ready`=0 holds all entries. Wakeup continues while held.
- Asynchronous reset mid-operation discards all entries immediately.

## Structure
- The shared package provides `alu_op_t`, `nzcv_t`, `GPR_SIZE` and `ROB_IDX_SIZE`. No new typedefs are needed beyond a package-local entry struct `rs_entry_t`.
- Sub-module `rs_age_select`: takes the age matrix and an eligible vector, and outputs a one-hot grant and an any_eligible flag. It is purely combinational.

## Test plan
- **Ready dispatch:** after reset, dispatch PLUS a=5, b=7, all ready, dst=3, `in_alu_ready`=1 → cycle N+1 has `out_alu_start`=1, val_a=5, val_b=7, dst=3; cycle N+2 has `out_alu_start`=0.
- **Wakeup:** dispatch MINUS with a waiting on ROB 2. Broadcast tag 2, value 40 → issue the next cycle with val_a=40. A broadcast on tag 4 leaves the entry waiting.
- **Same-cycle bypass and NZCV:** dispatch CSEL waiting on NZCV from ROB 1 while `in_fu_done`=1, tag 1, `set_nzcv`=1, nzcv=4'b0100 → issues the next cycle with nzcv=4'b0100. The same case with `in_fu_set_nzcv`=0 does not wake it.
- **Ordering and backpressure:** fill all 8 entries ready with `in_alu_ready`=0 → `out_dispatch_ready`=0 and the 9th dispatch is dropped. Release `in_alu_ready` → issues arrive in dispatch order.
- **Flush:** with 3 valid entries, assert `in_flush` together with a dispatch → the next cycle is empty, `out_dispatch_ready`=1 and there is no issue.
- **Reset:** assert `in_rst_n`=0 asynchronously mid-issue → outputs go to 0 immediately and the station is empty after release.
